// File: rtl/bus_serializer.sv
// Serialises one CPU bus request onto narrow address/data pins: address beats, a command beat,
// then write beats out or ext_ready-paced read beats in. Optional macro: BUS_SERIALIZER_TIMEOUT_EN.
module bus_serializer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PIN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              busy,
    output logic [PIN_W-1:0]  addr_pins,
    output logic [PIN_W-1:0]  data_out,
    output logic [PIN_W-1:0]  data_oe,
    input  logic [PIN_W-1:0]  data_in,
    input  logic              ext_ready
);
    localparam int NA        = ADDR_W / PIN_W;
    localparam int ND        = DATA_W / PIN_W;
    localparam int MAX_BEATS = (NA > ND) ? NA : ND;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    generate
        if ((ADDR_W % PIN_W) != 0 || (DATA_W % PIN_W) != 0 || PIN_W < 2) begin : g_bad_params
            $error("bus_serializer: ADDR_W and DATA_W must be multiples of PIN_W (PIN_W >= 2)");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CMD, S_WDATA, S_RDATA, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   beat_reg, beat_next;
    logic [ADDR_W-1:0]  addr_sh_reg, addr_sh_next;
    logic [DATA_W-1:0]  wdata_sh_reg, wdata_sh_next;
    logic               we_sh_reg, we_sh_next;
    logic               capture;
    logic [DATA_W-1:0]  rdata_assembled;

    logic [PIN_W-1:0]   addr_pins_reg, addr_pins_next;
    logic [PIN_W-1:0]   data_out_reg, data_out_next;
    logic [PIN_W-1:0]   data_oe_reg, data_oe_next;
    logic [DATA_W-1:0]  cpu_rdata_reg, cpu_rdata_next;
    logic               cpu_ack_reg, cpu_ack_next;
    logic               busy_reg, busy_next;

`ifdef BUS_SERIALIZER_TIMEOUT_EN
    logic [3:0]         stall_reg, stall_next;
    logic               timeout;
    logic               cpu_err_reg;
`endif

    // Read slots: each holds one captured beat; the final beat bypasses its slot so the
    // assembled word is ready at the edge that enters DONE.
    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_slot
            logic [PIN_W-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (capture && beat_reg == CNT_W'(gi)) begin
                    slot_reg <= data_in;
                end
            end
            assign rdata_assembled[gi*PIN_W +: PIN_W] =
                (beat_reg == CNT_W'(gi)) ? data_in : slot_reg;
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        beat_next     = beat_reg;
        addr_sh_next  = addr_sh_reg;
        wdata_sh_next = wdata_sh_reg;
        we_sh_next    = we_sh_reg;
        capture       = 1'b0;
`ifdef BUS_SERIALIZER_TIMEOUT_EN
        stall_next    = stall_reg;
        timeout       = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_sh_next  = cpu_addr;
                    wdata_sh_next = cpu_wdata;
                    we_sh_next    = cpu_we;
                    beat_next     = '0;
                    state_next    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (beat_reg == CNT_W'(NA - 1)) begin
                    beat_next  = '0;
                    state_next = S_CMD;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            S_CMD: begin
                beat_next  = '0;
                state_next = we_sh_reg ? S_WDATA : S_RDATA;
`ifdef BUS_SERIALIZER_TIMEOUT_EN
                stall_next = '0;
`endif
            end
            S_WDATA: begin
                if (beat_reg == CNT_W'(ND - 1)) begin
                    beat_next  = '0;
                    state_next = S_DONE;
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            S_RDATA: begin
                if (ext_ready) begin
                    capture = 1'b1;
`ifdef BUS_SERIALIZER_TIMEOUT_EN
                    stall_next = '0;
`endif
                    if (beat_reg == CNT_W'(ND - 1)) begin
                        beat_next  = '0;
                        state_next = S_DONE;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
`ifdef BUS_SERIALIZER_TIMEOUT_EN
                else if (stall_reg == 4'hF) begin
                    timeout    = 1'b1;
                    state_next = S_DONE;
                end else begin
                    stall_next = stall_reg + 1'b1;
                end
`endif
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pin values are computed from the upcoming state so the registered pins line up with it.
    always_comb begin
        addr_pins_next = '0;
        data_out_next  = '0;
        data_oe_next   = '0;
        case (state_next)
            S_ADDR:  addr_pins_next = addr_sh_next[int'(beat_next) * PIN_W +: PIN_W];
            S_CMD: begin
                addr_pins_next[0] = we_sh_next;
                addr_pins_next[1] = 1'b1;
            end
            S_WDATA: begin
                data_oe_next  = '1;
                data_out_next = wdata_sh_next[int'(beat_next) * PIN_W +: PIN_W];
            end
            default: ;
        endcase
        cpu_rdata_next = cpu_rdata_reg;
        if (capture && beat_reg == CNT_W'(ND - 1)) begin
            cpu_rdata_next = rdata_assembled;
        end
`ifdef BUS_SERIALIZER_TIMEOUT_EN
        if (timeout) begin
            cpu_rdata_next = '1;
        end
`endif
        cpu_ack_next = (state_next == S_DONE);
        busy_next    = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            beat_reg      <= '0;
            addr_sh_reg   <= '0;
            wdata_sh_reg  <= '0;
            we_sh_reg     <= 1'b0;
            addr_pins_reg <= '0;
            data_out_reg  <= '0;
            data_oe_reg   <= '0;
            cpu_rdata_reg <= '0;
            cpu_ack_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_reg      <= beat_next;
            addr_sh_reg   <= addr_sh_next;
            wdata_sh_reg  <= wdata_sh_next;
            we_sh_reg     <= we_sh_next;
            addr_pins_reg <= addr_pins_next;
            data_out_reg  <= data_out_next;
            data_oe_reg   <= data_oe_next;
            cpu_rdata_reg <= cpu_rdata_next;
            cpu_ack_reg   <= cpu_ack_next;
            busy_reg      <= busy_next;
        end
    end

`ifdef BUS_SERIALIZER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_reg   <= '0;
            cpu_err_reg <= 1'b0;
        end else begin
            stall_reg   <= stall_next;
            cpu_err_reg <= timeout;
        end
    end
    assign cpu_err = cpu_err_reg;
`else
    assign cpu_err = 1'b0;
`endif

    assign addr_pins = addr_pins_reg;
    assign data_out  = data_out_reg;
    assign data_oe   = data_oe_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_ack   = cpu_ack_reg;
    assign busy      = busy_reg;
endmodule

// File: tb/tb_bus_serializer.sv
// Randomised bench for bus_serializer: each transaction is expanded into an expected per-cycle
// pin trace from the protocol rules and compared cycle by cycle.
module tb_bus_serializer;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int PIN_W  = 8;
    localparam int NA     = ADDR_W / PIN_W;
    localparam int ND     = DATA_W / PIN_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic              busy;
    logic [PIN_W-1:0]  addr_pins;
    logic [PIN_W-1:0]  data_out;
    logic [PIN_W-1:0]  data_oe;
    logic [PIN_W-1:0]  data_in = '0;
    logic              ext_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int txn_no = 0;
    logic [DATA_W-1:0] exp_rdata = '0;

    bus_serializer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIN_W(PIN_W)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .busy(busy), .addr_pins(addr_pins), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in), .ext_ready(ext_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL txn %0d %s: got %h expected %h", txn_no, tag, got, exp);
        end
    endtask

    task automatic check_outs(input int cyc, input logic [PIN_W-1:0] e_addr,
                              input logic [PIN_W-1:0] e_dout, input logic [PIN_W-1:0] e_oe,
                              input logic e_busy, input logic e_ack, input logic e_err);
        check_val($sformatf("c%0d addr_pins", cyc), 64'(addr_pins), 64'(e_addr));
        check_val($sformatf("c%0d data_out", cyc), 64'(data_out), 64'(e_dout));
        check_val($sformatf("c%0d data_oe", cyc), 64'(data_oe), 64'(e_oe));
        check_val($sformatf("c%0d busy", cyc), 64'(busy), 64'(e_busy));
        check_val($sformatf("c%0d cpu_ack", cyc), 64'(cpu_ack), 64'(e_ack));
        check_val($sformatf("c%0d cpu_err", cyc), 64'(cpu_err), 64'(e_err));
        check_val($sformatf("c%0d cpu_rdata", cyc), 64'(cpu_rdata), 64'(exp_rdata));
    endtask

    // Builds the expected trace for one transaction, issues it, and checks every cycle.
    // abort_at >= 0 pulses rst in that trace cycle instead of completing.
    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int stall_max,
                           input int gap_beat, input int gap_len, input bit hold,
                           input bit stuck, input int abort_at,
                           input bit use_pat, input logic [DATA_W-1:0] rd_pat);
        logic [PIN_W-1:0]  ea[$];
        logic [PIN_W-1:0]  ed[$];
        logic [PIN_W-1:0]  eo[$];
        logic [PIN_W-1:0]  din[$];
        bit                rdy[$];
        logic [DATA_W-1:0] rd_model;
        logic [PIN_W-1:0]  cmd;
        logic [PIN_W-1:0]  beat;
        int                stalls;
        int                n;
        rd_model = '0;
        for (int k = 0; k < NA; k++) begin
            ea.push_back(PIN_W'(addr >> (k * PIN_W)));
            ed.push_back('0); eo.push_back('0);
            rdy.push_back(1'($urandom)); din.push_back(PIN_W'($urandom));
        end
        cmd = '0; cmd[0] = we; cmd[1] = 1'b1;
        ea.push_back(cmd); ed.push_back('0); eo.push_back('0);
        rdy.push_back(1'($urandom)); din.push_back(PIN_W'($urandom));
        if (we) begin
            for (int k = 0; k < ND; k++) begin
                ea.push_back('0); ed.push_back(PIN_W'(wdata >> (k * PIN_W))); eo.push_back('1);
                rdy.push_back(1'($urandom)); din.push_back(PIN_W'($urandom));
            end
        end else if (stuck) begin
            rd_model = '1;
            for (int k = 0; k < 16; k++) begin
                ea.push_back('0); ed.push_back('0); eo.push_back('0);
                rdy.push_back(1'b0); din.push_back(PIN_W'($urandom));
            end
        end else begin
            for (int k = 0; k < ND; k++) begin
                stalls = ((k == gap_beat) ? gap_len : 0) + int'($urandom_range(0, stall_max));
                for (int s = 0; s < stalls; s++) begin
                    ea.push_back('0); ed.push_back('0); eo.push_back('0);
                    rdy.push_back(1'b0); din.push_back(PIN_W'($urandom));
                end
                beat = use_pat ? PIN_W'(rd_pat >> (k * PIN_W)) : PIN_W'($urandom);
                rd_model[k*PIN_W +: PIN_W] = beat;
                ea.push_back('0); ed.push_back('0); eo.push_back('0);
                rdy.push_back(1'b1); din.push_back(beat);
            end
        end
        ea.push_back('0); ed.push_back('0); eo.push_back('0);
        rdy.push_back(1'($urandom)); din.push_back(PIN_W'($urandom));
        n = ea.size();

        @(negedge clk);
        check_val("idle busy", 64'(busy), 64'(0));
        check_val("idle cpu_ack", 64'(cpu_ack), 64'(0));
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_req = hold; cpu_we = 1'($urandom); cpu_addr = ADDR_W'($urandom);
        cpu_wdata = DATA_W'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1 && !we) exp_rdata = rd_model;
            check_outs(i, ea[i], ed[i], eo[i], 1'b1, (i == n - 1), (i == n - 1) && stuck);
            if (i == abort_at) begin
                rst = 1'b1; cpu_req = 1'b0;
                @(negedge clk);
                exp_rdata = '0;
                check_outs(-1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
                rst = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check_outs(-2 - j, '0, '0, '0, 1'b0, 1'b0, 1'b0);
                end
                $display("txn %0d we=%0d addr=%h aborted by rst at trace cycle %0d",
                         txn_no, we, addr, i);
                txn_no++;
                return;
            end
            ext_ready = rdy[i];
            data_in   = din[i];
        end
        $display("txn %0d we=%0d addr=%h wdata=%h rdata=%h ack_after=%0d cycles",
                 txn_no, we, addr, wdata, exp_rdata, n);
        txn_no++;
    endtask

    initial begin
        bit hold;
        bit prev_hold;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs(-100, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run_txn(1'b1, 32'h12345678, 32'hCAFEBABE, 0, -1, 0, 1'b0, 1'b0, -1, 1'b0, '0);
        run_txn(1'b0, 32'h0000A5A5, '0, 0, -1, 0, 1'b0, 1'b0, -1, 1'b1, 32'h44332211);
        run_txn(1'b0, 32'h0000A5A5, '0, 0, 2, 3, 1'b0, 1'b0, -1, 1'b1, 32'h44332211);
        run_txn(1'b1, 32'hDEADBEEF, 32'h01234567, 0, -1, 0, 1'b0, 1'b0, NA + 1 + 2, 1'b0, '0);
        run_txn(1'b0, 32'h87654321, '0, 1, -1, 0, 1'b0, 1'b0, -1, 1'b0, '0);
        run_txn(1'b1, 32'h11111111, 32'hAAAA5555, 0, -1, 0, 1'b1, 1'b0, -1, 1'b0, '0);
        run_txn(1'b1, 32'h22222222, 32'h5555AAAA, 0, -1, 0, 1'b0, 1'b0, -1, 1'b0, '0);
`ifdef BUS_SERIALIZER_TIMEOUT_EN
        run_txn(1'b0, 32'h33333333, '0, 0, -1, 0, 1'b0, 1'b1, -1, 1'b0, '0);
        run_txn(1'b0, 32'h44444444, '0, 2, -1, 0, 1'b0, 1'b0, -1, 1'b0, '0);
`endif
        prev_hold = 1'b0;
        for (int t = 0; t < 40; t++) begin
            hold = (t < 39) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), 3, -1, 0, hold,
                    1'b0, -1, 1'b0, '0);
            prev_hold = hold;
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_outs(-200 - j, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_serializer.md
# bus_serializer

Parametrised bridge between the CPU core's parallel memory bus and a narrow off-chip pin interface. Captures one CPU request, then walks it across the pins as address beats, a command beat, and either outgoing write-data beats or incoming read-data beats. Incoming read beats are paced by an external ready strobe, and completion is signalled back to the CPU with a single-cycle acknowledge. It sits between `cpu` and the top-level pad wrapper, replacing the fixed 32-bit/8-pin counter sequencer.

## Interface

Parameters:
- `ADDR_W`, default 32: CPU address width; must be a multiple of `PIN_W`.
- `DATA_W`, default 32: CPU data width; must be a multiple of `PIN_W`.
- `PIN_W`, default 8: width of the address pins and of the data pins.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cpu_req`  in  1  transaction request; sampled only in IDLE.
- `cpu_we`  in  1  1 = write, 0 = read; captured with the request.
- `cpu_addr`  in  ADDR_W  address; captured with the request.
- `cpu_wdata`  in  DATA_W  write data; captured with the request.
- `cpu_rdata`  out  DATA_W  assembled read data; held until the next read completes.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  timeout flag; valid with `cpu_ack`; tied 0 without the macro.
- `busy`  out  1  high in every state except IDLE.
- `addr_pins`  out  PIN_W  address and command beats.
- `data_out`  out  PIN_W  write-data beats.
- `data_oe`  out  PIN_W  data pin direction; all ones = drive, all zeros = input.
- `data_in`  in  PIN_W  read-data beats.
- `ext_ready`  in  1  read beat valid; ignored outside RDATA.

## Operation

- Derived counts: NA = ADDR_W/PIN_W address beats; ND = DATA_W/PIN_W data beats. A non-integer ratio is an elaboration error.
- States: IDLE, ADDR, CMD, WDATA, RDATA, DONE.
- IDLE:
  - If `cpu_req`=1: latch `cpu_addr`, `cpu_we` and `cpu_wdata` into shadow registers, clear the beat counter, and go to ADDR.
  - CPU inputs are ignored in every other state.
- ADDR:
  - Beat k (k = 0..NA-1) drives shadow address bits [k*PIN_W +: PIN_W]; least-significant beat first.
  - After NA beats, go to CMD.
- CMD:
  - One cycle. `addr_pins[0]` = we, `addr_pins[1]` = 1 (strobe); all other bits 0.
  - Go to WDATA if we = 1, else RDATA.
- WDATA:
  - `data_oe` = all ones. Beat k drives shadow wdata [k*PIN_W +: PIN_W].
  - After ND beats, go to DONE.
- RDATA:
  - `data_oe` = 0.
  - Each cycle with `ext_ready`=1 stores `data_in` into read slot k, then increments k. The first sampled beat lands in bits [PIN_W-1:0].
  - Cycles with `ext_ready`=0 stall without advancing.
  - After ND captured beats, go to DONE.
- DONE:
  - `cpu_ack`=1 for exactly this cycle; go to IDLE.
  - On reads, `cpu_rdata` updates at the DONE entry edge.
- `addr_pins` is 0 outside ADDR and CMD. `data_out` is 0 and `data_oe` is 0 outside WDATA.
- All pin outputs are registered; there is no combinational path from any input to any output.

## Timing

- Reset values: `addr_pins`=0, `data_out`=0, `data_oe`=0, `cpu_rdata`=0, `cpu_ack`=0, `cpu_err`=0, `busy`=0, state = IDLE.
- Let edge T be the edge that samples `cpu_req`=1 in IDLE.
  - ADDR occupies cycles T+1..T+NA.
  - CMD occupies cycle T+NA+1.
  - The data phase starts at T+NA+2.
  - Writes: `cpu_ack` in cycle T+NA+ND+2, which is T+10 at the defaults.
  - Reads: `cpu_ack` in cycle T+NA+ND+2+S, where S is the number of stalled RDATA cycles.
- Back-to-back requests: at least one IDLE cycle separates DONE from the next accept. If `cpu_req` is held high, the next accept happens at the edge leaving that IDLE cycle.
- `rst` asserted in any state: return to IDLE next edge with all outputs at reset values. No `cpu_ack` is issued for the aborted transaction, and the partial read is discarded.
- Write transactions never look at `ext_ready`.

## Configuration

- `BUS_SERIALIZER_TIMEOUT_EN` defined: a 4-bit stall counter runs in RDATA.
  - The counter clears on every `ext_ready`=1 cycle.
  - On the 16th consecutive stall cycle: go to DONE, set `cpu_rdata` to all ones, and assert `cpu_err`=1 together with `cpu_ack`.
  - `cpu_err` returns to 0 in the following cycle.
- Undefined: RDATA waits indefinitely for `ext_ready`; `cpu_err` is constant 0 and the counter logic is absent.

## Test plan

- Write, defaults, `cpu_addr`=0x12345678, `cpu_wdata`=0xCAFEBABE:
  - `addr_pins` = 78,56,34,12, then 0x03.
  - `data_out` = BE,BA,FE,CA with `data_oe`=0xFF.
  - `cpu_ack` at T+10.
- Read, `ext_ready`=1 throughout, `data_in` beats 0x11,0x22,0x33,0x44: CMD beat 0x02, `data_oe`=0, `cpu_rdata`=0x44332211, `cpu_ack` at T+10.
- Read with `ext_ready` low for 3 cycles between beats 1 and 2: `cpu_ack` at T+13, same `cpu_rdata`.
- `rst` pulsed during WDATA beat 2: next cycle all outputs 0, state IDLE, no `cpu_ack`. A following read completes normally.
- `cpu_req` held high across two writes: second ADDR beat 0 appears exactly 2 cycles after the first `cpu_ack`.
- With `BUS_SERIALIZER_TIMEOUT_EN`, read with `ext_ready` stuck 0: `cpu_ack`=1, `cpu_err`=1, `cpu_rdata`=0xFFFFFFFF in cycle T+NA+2+16.
